// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-boundary registers: state encoding,
// MEM/WB payload layout and a helper that packs a MEM/WB bundle.
package pipe_pkg;

    // Default payload is the MEM/WB bundle
    localparam int unsigned MEMWB_DATA_W = 104;
    localparam int unsigned MEMWB_CTRL_W = 3;

    // Occupancy counter width (0..2 held beats)
    localparam int unsigned OCC_W = 2;

    // One-hot state encoding; the bit positions are decoded directly
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_ONE_BIT   = 1;
    localparam int unsigned ST_TWO_BIT   = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_EMPTY = 3'b001;
    localparam state_t ST_ONE   = 3'b010;
    localparam state_t ST_TWO   = 3'b100;

    // MEM/WB payload field offsets
    localparam int unsigned CTRL_LSB     = 0;
    localparam int unsigned WRITEREG_LSB = 3;
    localparam int unsigned PCPLUS4_LSB  = 8;
    localparam int unsigned READDATA_LSB = 40;
    localparam int unsigned ALUOUT_LSB   = 72;

    // Field widths of the MEM/WB bundle
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned WRITEREG_W = 5;

    // Packs a MEM/WB bundle; control bits are {RegWrite, MemtoReg, JumpLink}
    function automatic logic [MEMWB_DATA_W-1:0] packMemWb(
        input logic [WORD_W-1:0]     aluOut,
        input logic [WORD_W-1:0]     readData,
        input logic [WORD_W-1:0]     pcPlus4,
        input logic [WRITEREG_W-1:0] writeReg,
        input logic                  regWrite,
        input logic                  memtoReg,
        input logic                  jumpLink
    );
        logic [MEMWB_DATA_W-1:0] r;
        r = '0;
        r[ALUOUT_LSB   +: WORD_W]       = aluOut;
        r[READDATA_LSB +: WORD_W]       = readData;
        r[PCPLUS4_LSB  +: WORD_W]       = pcPlus4;
        r[WRITEREG_LSB +: WRITEREG_W]   = writeReg;
        r[CTRL_LSB     +: MEMWB_CTRL_W] = {regWrite, memtoReg, jumpLink};
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline boundary, plus the flush
// and occupancy sideband. slave = the stage register, master = its driver.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = MEMWB_DATA_W
);

    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [OCC_W-1:0]  occupancy;

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output occupancy
    );

    modport master (
        output flush,
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  occupancy
    );

endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-boundary register with a 2-entry skid buffer.
// in_ready and out_valid are straight decodes of the one-hot state flop,
// so no ready path is combinational from downstream.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = MEMWB_DATA_W,
    parameter int unsigned CTRL_W = MEMWB_CTRL_W
) (
    input logic               CLK,
    input logic               RST,
    pipe_stage_skid_if.slave  bus
);

    state_t            stateQ;
    state_t            stateD;
    logic [DATA_W-1:0] mainQ;
    logic [DATA_W-1:0] skidQ;

    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;
    logic              inFire;
    logic              outFire;

    logic              inReady;
    logic              outValid;
    logic [OCC_W-1:0]  occupancy;
    logic [DATA_W-1:0] outData;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ <= ST_EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state and storage-load decode; flush overrides everything
    always_comb begin
        stateD       = stateQ;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        inFire       = bus.in_valid & inReady;
        outFire      = outValid & bus.out_ready;

        if (bus.flush) begin
            stateD = ST_EMPTY;
        end else begin
            case (stateQ)
                ST_EMPTY: begin
                    if (inFire) begin
                        stateD     = ST_ONE;
                        loadMainIn = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (inFire && outFire) begin
                        loadMainIn = 1'b1;
                    end else if (inFire) begin
                        stateD   = ST_TWO;
                        loadSkid = 1'b1;
                    end else if (outFire) begin
                        stateD = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain can happen
                    if (outFire) begin
                        stateD       = ST_ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: begin
                    stateD = ST_EMPTY;
                end
            endcase
        end
    end

    // Output decode from the state flop; control bits masked on bubbles
    always_comb begin
        inReady   = ~stateQ[ST_TWO_BIT];
        outValid  = ~stateQ[ST_EMPTY_BIT];
        occupancy = OCC_W'(0);
        if (stateQ[ST_ONE_BIT]) begin
            occupancy = OCC_W'(1);
        end
        if (stateQ[ST_TWO_BIT]) begin
            occupancy = OCC_W'(2);
        end
        outData = mainQ;
        for (int unsigned i = 0; i < CTRL_W; i++) begin
            outData[i] = mainQ[i] & outValid;
        end
    end

    // Payload storage: main drives the output, skid absorbs one stalled beat
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            if (loadMainIn) begin
                mainQ <= bus.in_data;
            end else if (loadMainSkid) begin
                mainQ <= skidQ;
            end
            if (loadSkid) begin
                skidQ <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.occupancy = occupancy;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: stimulus pushes the hand-derived
// delivered sequence into a queue, a negedge monitor pops on each out_fire.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned DW = MEMWB_DATA_W;

    logic CLK;
    logic RST;

    pipe_stage_skid_if #(.DATA_W(DW)) bus ();

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(MEMWB_CTRL_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_data  = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: compares each delivered beat and output stability
    always @(negedge CLK) begin
        if (RST) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid && bus.out_valid)
                check("stall_stable", bus.out_data, hold_data);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", bus.out_data);
                end else begin
                    check("beat_data", bus.out_data, exp_q.pop_front());
                end
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] pay;
        logic [DW-1:0] upper_mask;

        RST           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) step();
        check("rst_out_valid", DW'(bus.out_valid), DW'(0));
        check("rst_in_ready",  DW'(bus.in_ready),  DW'(1));
        check("rst_occupancy", DW'(bus.occupancy), DW'(0));
        check("rst_out_data",  bus.out_data,       DW'(0));
        RST = 1'b0;

        // Streaming 0x01..0x08 with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
            exp_q.push_back(DW'(i));
            step();
            check("stream_occ",   DW'(bus.occupancy), DW'(1));
            check("stream_valid", DW'(bus.out_valid), DW'(1));
            check("stream_data",  bus.out_data,       DW'(i));
        end
        bus.in_valid = 1'b0;
        step();
        check("stream_drain_occ", DW'(bus.occupancy), DW'(0));

        // Back-pressure: A, B held; C stalled; release yields A, B, C
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(8'h11);
        exp_q.push_back(DW'(8'h11));
        exp_q.push_back(DW'(8'h22));
        exp_q.push_back(DW'(8'h33));
        step();
        check("bp_occ_one", DW'(bus.occupancy), DW'(1));
        bus.in_data = DW'(8'h22);
        step();
        check("bp_occ_two",   DW'(bus.occupancy), DW'(2));
        check("bp_ready_low", DW'(bus.in_ready),  DW'(0));
        bus.in_data = DW'(8'h33);
        step();
        check("bp_c_stalled_occ",   DW'(bus.occupancy), DW'(2));
        check("bp_c_stalled_ready", DW'(bus.in_ready),  DW'(0));
        check("bp_head_a",          bus.out_data,       DW'(8'h11));
        bus.out_ready = 1'b1;
        step();
        check("bp_release_ready", DW'(bus.in_ready),  DW'(1));
        check("bp_release_occ",   DW'(bus.occupancy), DW'(1));
        check("bp_release_head",  bus.out_data,       DW'(8'h22));
        step();
        check("bp_c_accepted", bus.out_data, DW'(8'h33));
        bus.in_valid = 1'b0;
        step();
        check("bp_drained", DW'(bus.occupancy), DW'(0));

        // Flush in TWO with 0x44 offered: nothing reaches downstream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(8'h11);
        step();
        bus.in_data = DW'(8'h22);
        step();
        check("fl_two_occ", DW'(bus.occupancy), DW'(2));
        bus.in_data = DW'(8'h44);
        bus.flush   = 1'b1;
        step();
        check("fl_out_valid", DW'(bus.out_valid), DW'(0));
        check("fl_in_ready",  DW'(bus.in_ready),  DW'(1));
        check("fl_occ",       DW'(bus.occupancy), DW'(0));
        check("fl_ctrl_zero", bus.out_data & DW'(3'b111), DW'(0));
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("fl_still_empty", DW'(bus.out_valid), DW'(0));

        // ONE with in_fire, out_fire and flush together
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(8'h66);
        exp_q.push_back(DW'(8'h66));
        step();
        bus.out_ready = 1'b1;
        bus.in_data   = DW'(8'h77);
        bus.flush     = 1'b1;
        step();
        check("sim_occ",       DW'(bus.occupancy), DW'(0));
        check("sim_out_valid", DW'(bus.out_valid), DW'(0));
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("sim_dropped", DW'(bus.out_valid), DW'(0));

        // Control masking on the idle cycle after a MEM/WB beat
        pay = packMemWb(32'hDEADBEEF, 32'hCAFEF00D, 32'h00000104, 5'd9, 1'b1, 1'b1, 1'b1);
        upper_mask = ~DW'(3'b111);
        bus.in_valid = 1'b1;
        bus.in_data  = pay;
        exp_q.push_back(pay);
        step();
        check("mask_live_beat", bus.out_data, pay);
        bus.in_valid = 1'b0;
        step();
        check("mask_idle_valid", DW'(bus.out_valid), DW'(0));
        check("mask_idle_ctrl",  bus.out_data & DW'(3'b111), DW'(0));
        check("mask_idle_upper", bus.out_data & upper_mask, pay & upper_mask);

        // Asynchronous reset while in TWO
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(8'h81);
        step();
        bus.in_data = DW'(8'h82);
        step();
        check("mid_two_occ", DW'(bus.occupancy), DW'(2));
        bus.in_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
        check("mid_rst_in_ready",  DW'(bus.in_ready),  DW'(1));
        check("mid_rst_occ",       DW'(bus.occupancy), DW'(0));
        check("mid_rst_out_data",  bus.out_data,       DW'(0));
        step();
        RST           = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(8'h90);
        exp_q.push_back(DW'(8'h90));
        step();
        check("post_rst_occ",  DW'(bus.occupancy), DW'(1));
        check("post_rst_data", bus.out_data,       DW'(8'h90));
        bus.in_valid = 1'b0;
        step();
        check("post_rst_drain", DW'(bus.occupancy), DW'(0));

        repeat (2) step();
        check("queue_drained", DW'(exp_q.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline-boundary register with a valid/ready handshake, synchronous flush and a 2-entry skid buffer. It is the successor to the fixed MEM/WB flip-flop and carries any stage payload (default: the MEM/WB bundle) across a stage boundary. Back-pressure never loses a beat, bubbles never present live control bits downstream, and `in_ready` comes straight from a flop, so no ready path is combinational.

## Interface
- `DATA_W`, 104: payload width. The default is the MEM/WB bundle: ALUOut 32 + ReadData 32 + PCPlus4 32 + WriteReg 5 + RegWrite/MemtoReg/JumpLink 3.
- `CTRL_W`, 3: number of low payload bits that are control (write enables). Must satisfy 1 ≤ CTRL_W ≤ DATA_W.
- `CLK`, in, 1: clock. All state updates on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `flush`, in, 1: synchronous squash of all held and incoming beats.
- `in_valid`, in, 1: upstream beat present.
- `in_data`, in, DATA_W: upstream payload.
- `in_ready`, out, 1: block accepts a beat this cycle. Registered.
- `out_valid`, out, 1: downstream beat present.
- `out_data`, out, DATA_W: downstream payload. Bits [CTRL_W-1:0] are 0 whenever `out_valid`=0.
- `out_ready`, in, 1: downstream accepts the beat.
- `occupancy`, out, 2: number of held beats, 0..2.

## Operation
- Fires: `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- Storage: `main` register (drives `out_data`) and `skid` register.
- States:
  - EMPTY (occupancy 0)
  - ONE (`main` valid)
  - TWO (`main` and `skid` valid)
- Derived outputs: `out_valid` = (state≠EMPTY); `in_ready` = (state≠TWO). `in_ready` is decoded from a one-hot state flop, not from `out_ready`.
- Transitions when `flush`=0:
  - EMPTY: `in_fire` → ONE, `main`←`in_data`.
  - ONE:
    - `in_fire` & `out_fire` → ONE, `main`←`in_data`.
    - `in_fire` & !`out_fire` → TWO, `skid`←`in_data`.
    - !`in_fire` & `out_fire` → EMPTY.
    - Otherwise hold.
  - TWO: `out_fire` → ONE, `main`←`skid`. Otherwise hold. `in_fire` is impossible here.
- Flush has the highest priority: next state is EMPTY and the beat offered that cycle is dropped, even if `in_fire`=1. `out_fire` in the same cycle still counts as delivered.
- Control masking: `out_data`[CTRL_W-1:0] = `main`[CTRL_W-1:0] & {CTRL_W{`out_valid`}}. Upper bits pass `main` unmasked.
- Data order is strictly FIFO. No beat is duplicated or dropped except by flush.
- `out_data` stays stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values (asynchronous, held while `RST`=1):
  - state EMPTY
  - `main`=0, `skid`=0
  - `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid`=1 after edge N. With `out_ready` held at 1, the stage adds exactly 1 cycle.
- Throughput: 1 beat/cycle sustained with `out_ready`=1.
- Back-pressure: after `out_ready` drops, at most one further beat is accepted (into `skid`), then `in_ready`=0 from the next cycle.
- When `out_ready` rises in TWO, `in_ready` returns to 1 the following cycle. This is a one-cycle penalty, by design.
- Reset mid-operation: held beats are discarded immediately and outputs go to reset values asynchronously. The first acceptance is possible on the first edge after `RST` deasserts.
- Flush is effective at the next edge: the cycle after a flush has `out_valid`=0, `in_ready`=1, `occupancy`=0.

## Structure
- Shared package `pipe_pkg`:
  - state encoding localparams ST_EMPTY, ST_ONE, ST_TWO (one-hot, 3 bits)
  - MEM/WB payload field offsets (CTRL_LSB=0, WRITEREG_LSB=3, PCPLUS4_LSB=8, READDATA_LSB=40, ALUOUT_LSB=72)
  - default DATA_W
- No sub-module. Control-bit masking and the state machine live in this module.
- Instantiation requirement: MEM/WB instances pack RegWrite/MemtoReg/JumpLink into bits [2:0].

## Test plan
- Reset: assert `RST` mid-stream while in TWO → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0 before the next edge.
- Streaming: 8 beats 0x01..0x08, `out_ready`=1 → the same sequence appears one cycle later, no gaps, `occupancy`=1 throughout.
- Back-pressure: beats A=0x11, B=0x22, C=0x33 offered while `out_ready`=0 → A and B held, `occupancy`=2, `in_ready`=0, C stalled. Releasing `out_ready` yields A, B, C in order, with no loss.
- Flush in TWO with `in_valid`=1 (beat 0x44) → the next cycle is EMPTY, and 0x44, A and B never appear downstream.
- Control masking: payload with bits [2:0]=3'b111 followed by an idle cycle → `out_data`[2:0]=0 in the idle cycle while upper bits hold the last `main`.
- Simultaneous events: in ONE with `in_fire`, `out_fire` and `flush` all 1 → the old beat counts as delivered, the new beat is dropped, and the state becomes EMPTY.
